// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-port arbiter in front of one shared external ALU. It grants
//            one requester, captures that port's operands into the ALU
//            operand registers, then stores the ALU result and compare flags
//            for that port. Each operation takes IDLE -> EXEC -> DONE.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int unsigned RR_EN = 1  // 1: round-robin, 0: port 0 always wins
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // port 0
  input  logic        req0_i,
  input  logic [15:0] a0_i,
  input  logic [15:0] b0_i,
  input  logic [3:0]  op0_i,
  output logic        gnt0_o,
  output logic        done0_o,
  output logic [15:0] res0_o,
  output logic [2:0]  flg0_o,
  // port 1
  input  logic        req1_i,
  input  logic [15:0] a1_i,
  input  logic [15:0] b1_i,
  input  logic [3:0]  op1_i,
  output logic        gnt1_o,
  output logic        done1_o,
  output logic [15:0] res1_o,
  output logic [2:0]  flg1_o,
  // shared ALU
  output logic [15:0] alu_data1_o,
  output logic [15:0] alu_data2_o,
  output logic [3:0]  alu_op_o,
  input  logic [15:0] alu_result_i,
  input  logic        alu_zero_i,
  input  logic        alu_lt_i,
  input  logic        alu_gt_i,
  // status
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        owner_q;   // port that owns the operation in flight
  logic        last_q;    // port granted most recently (round-robin pointer)
  logic        owner_d;   // port that wins if a grant happens this cycle
  logic        gnt0_q, gnt1_q;
  logic        done0_q, done1_q;
  logic        busy_q;
  logic [15:0] res0_q, res1_q;
  logic [2:0]  flg0_q, flg1_q;
  logic [15:0] data1_q, data2_q;
  logic [3:0]  op_q;

  // Winner selection: a lone requester always wins; on contention the
  // round-robin pointer favours the port that was not granted last.
  always_comb begin
    owner_d = 1'b0;
    if (req0_i && req1_i) begin
      owner_d = (RR_EN != 0) ? ~last_q : 1'b0;
    end else if (req1_i) begin
      owner_d = 1'b1;
    end
  end

  // Control FSM with all outputs registered; reset aborts any operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;   // port 0 wins the first contention after reset
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      res0_q  <= 16'h0000;
      res1_q  <= 16'h0000;
      flg0_q  <= 3'b000;
      flg1_q  <= 3'b000;
      data1_q <= 16'h0000;
      data2_q <= 16'h0000;
      op_q    <= 4'b0000;
    end else begin
      // grant and done are single-cycle pulses
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req0_i || req1_i) begin
            state_q <= ST_EXEC;
            busy_q  <= 1'b1;
            owner_q <= owner_d;
            last_q  <= owner_d;
            gnt0_q  <= ~owner_d;
            gnt1_q  <= owner_d;
            // operand registers change only here, so they hold while idle
            data1_q <= owner_d ? a1_i  : a0_i;
            data2_q <= owner_d ? b1_i  : b0_i;
            op_q    <= owner_d ? op1_i : op0_i;
          end
        end
        ST_EXEC: begin
          state_q <= ST_DONE;
          if (owner_q) begin
            res1_q  <= alu_result_i;
            flg1_q  <= {alu_zero_i, alu_lt_i, alu_gt_i};
            done1_q <= 1'b1;
          end else begin
            res0_q  <= alu_result_i;
            flg0_q  <= {alu_zero_i, alu_lt_i, alu_gt_i};
            done0_q <= 1'b1;
          end
        end
        ST_DONE: begin
          // requests are not sampled here; a held req is seen next cycle
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign done0_o     = done0_q;
  assign done1_o     = done1_q;
  assign res0_o      = res0_q;
  assign res1_o      = res1_q;
  assign flg0_o      = flg0_q;
  assign flg1_o      = flg1_q;
  assign alu_data1_o = data1_q;
  assign alu_data2_o = data2_q;
  assign alu_op_o    = op_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Bench for alu_arbiter. Instance 0 uses round-robin, instance 1
//            fixed priority; both share the request stimulus and each has its
//            own behavioural ALU. An operation-level model predicts outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;

  // index 0: RR_EN=1, index 1: RR_EN=0
  logic [1:0]       gnt0, gnt1, done0, done1, busy;
  logic [1:0][15:0] res0, res1, d1, d2;
  logic [1:0][2:0]  flg0, flg1;
  logic [1:0][3:0]  aop;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference ALU: returns {zero, lt, gt, result}; undefined codes add.
  function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    logic [15:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0110: r = (a < b) ? 16'd1 : 16'd0;
      4'b0111: r = a << b[3:0];
      4'b1000: r = a >> b[3:0];
      default: r = a + b;
    endcase
    return {(r == 16'h0000), (a < b), (a > b), r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [18:0] alu_out;
    assign alu_out = alu_f(d1[g], d2[g], aop[g]);

    alu_arbiter #(.RR_EN((g == 0) ? 1 : 0)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req0_i      (req0),
      .a0_i        (a0),
      .b0_i        (b0),
      .op0_i       (op0),
      .gnt0_o      (gnt0[g]),
      .done0_o     (done0[g]),
      .res0_o      (res0[g]),
      .flg0_o      (flg0[g]),
      .req1_i      (req1),
      .a1_i        (a1),
      .b1_i        (b1),
      .op1_i       (op1),
      .gnt1_o      (gnt1[g]),
      .done1_o     (done1[g]),
      .res1_o      (res1[g]),
      .flg1_o      (flg1[g]),
      .alu_data1_o (d1[g]),
      .alu_data2_o (d2[g]),
      .alu_op_o    (aop[g]),
      .alu_result_i(alu_out[15:0]),
      .alu_zero_i  (alu_out[18]),
      .alu_lt_i    (alu_out[17]),
      .alu_gt_i    (alu_out[16]),
      .busy_o      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- operation-level model ----------------
  // An operation is in flight for two cycles after its grant edge:
  // age 1 = grant cycle, age 2 = completion cycle.
  bit          m_busy [2];
  int          m_age  [2];
  int          m_own  [2];
  int          m_last [2];
  logic [15:0] m_a    [2];
  logic [15:0] m_b    [2];
  logic [3:0]  m_op   [2];
  logic [15:0] m_res  [2][2];
  logic [2:0]  m_flg  [2][2];

  always @(posedge clk or negedge rst_n) begin : p_model
    logic [18:0] r;
    int w;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_age[i] = 0; m_own[i] = 0; m_last[i] = 1;
        m_a[i] = '0; m_b[i] = '0; m_op[i] = '0;
        for (int p = 0; p < 2; p++) begin m_res[i][p] = '0; m_flg[i][p] = '0; end
      end else if (m_busy[i]) begin
        if (m_age[i] == 1) begin
          m_age[i] = 2;
          r = alu_f(m_a[i], m_b[i], m_op[i]);
          m_res[i][m_own[i]] = r[15:0];
          m_flg[i][m_own[i]] = r[18:16];
        end else begin
          m_busy[i] = 1'b0; m_age[i] = 0;
        end
      end else if (req0 || req1) begin
        if (req0 && req1) w = (i == 0) ? 1 - m_last[i] : 0;
        else              w = req1 ? 1 : 0;
        m_busy[i] = 1'b1; m_age[i] = 1; m_own[i] = w; m_last[i] = w;
        m_a[i]  = (w == 1) ? a1  : a0;
        m_b[i]  = (w == 1) ? b1  : b0;
        m_op[i] = (w == 1) ? op1 : op0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin : p_compare
    string n;
    #1;
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? "rr" : "fp";
      chk({n, ".gnt0"},  gnt0[i],  m_busy[i] && m_age[i] == 1 && m_own[i] == 0);
      chk({n, ".gnt1"},  gnt1[i],  m_busy[i] && m_age[i] == 1 && m_own[i] == 1);
      chk({n, ".done0"}, done0[i], m_busy[i] && m_age[i] == 2 && m_own[i] == 0);
      chk({n, ".done1"}, done1[i], m_busy[i] && m_age[i] == 2 && m_own[i] == 1);
      chk({n, ".busy"},  busy[i],  m_busy[i]);
      chk({n, ".res0"},  res0[i],  m_res[i][0]);
      chk({n, ".res1"},  res1[i],  m_res[i][1]);
      chk({n, ".flg0"},  flg0[i],  m_flg[i][0]);
      chk({n, ".flg1"},  flg1[i],  m_flg[i][1]);
      chk({n, ".data1"}, d1[i],    m_a[i]);
      chk({n, ".data2"}, d2[i],    m_b[i]);
      chk({n, ".op"},    aop[i],   m_op[i]);
    end
  end

  // Wait (bounded) until both instances are idle; called at a falling edge.
  task automatic wait_idle();
    int n = 0;
    while (busy != 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle.busy", busy, 2'b00);
  endtask

  // One directed operation from a single port with literal expectations.
  task automatic do_op(input int p, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic [15:0] er, input logic [2:0] ef);
    wait_idle();
    if (p == 0) begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; req1 = 1'b0; end
    else        begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; req0 = 1'b0; end
    @(negedge clk);
    chk($sformatf("op%0d.gnt", p), (p == 0) ? gnt0[0] : gnt1[0], 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("op%0d.done[%0d]", p, i), (p == 0) ? done0[i] : done1[i], 1'b1);
      chk($sformatf("op%0d.res[%0d]", p, i),  (p == 0) ? res0[i]  : res1[i],  er);
      chk($sformatf("op%0d.flg[%0d]", p, i),  (p == 0) ? flg0[i]  : flg1[i],  ef);
    end
  endtask

  initial begin : p_stim
    int gord[$];
    int dord[$];
    int dcyc[$];
    int fp_g0, fp_g1;
    fp_g0 = 0; fp_g1 = 0;

    // reset with both ports already requesting
    rst_n = 1'b0;
    req0 = 1'b1; a0 = 16'd10; b0 = 16'd4; op0 = 4'b0001;
    req1 = 1'b1; a1 = 16'd7;  b1 = 16'd7; op1 = 4'b0100;
    repeat (3) @(negedge clk);
    chk("rst.busy",  busy,     2'b00);
    chk("rst.gnt",   {gnt0[0], gnt1[0]}, 2'b00);
    chk("rst.res0",  res0[0],  16'h0000);
    chk("rst.flg1",  flg1[0],  3'b000);
    chk("rst.op",    aop[0],   4'b0000);
    rst_n = 1'b1;

    // contention: grants 0,1,0,1 under round-robin, port 0 only under fixed
    repeat (12) begin
      @(negedge clk);
      if (gnt0[0]) gord.push_back(0);
      if (gnt1[0]) gord.push_back(1);
      if (done0[0]) begin dord.push_back(0); dcyc.push_back(cyc); end
      if (done1[0]) begin dord.push_back(1); dcyc.push_back(cyc); end
      if (gnt0[1]) fp_g0++;
      if (gnt1[1]) fp_g1++;
    end
    chk("rr.ngrant", gord.size(), 4);
    chk("rr.ndone",  dord.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gord.size()) chk($sformatf("rr.grant[%0d]", k), gord[k], k % 2);
      if (k < dord.size()) chk($sformatf("rr.done[%0d]", k),  dord[k], k % 2);
      if (k > 0 && k < dcyc.size()) chk($sformatf("rr.dgap[%0d]", k), dcyc[k] - dcyc[k-1], 3);
    end
    chk("fp.ngnt0", fp_g0, 4);
    chk("fp.ngnt1", fp_g1, 0);
    chk("fp.res1",  res1[1], 16'h0000);
    req0 = 1'b0; req1 = 1'b0;

    // directed operations
    do_op(0, 16'd5, 16'd3, 4'b0001, 16'd2, 3'b001);
    do_op(1, 16'h00FF, 16'h00FF, 4'b0100, 16'h0000, 3'b100);
    chk("eq.res0_kept", res0[0], 16'd2);
    chk("eq.flg0_kept", flg0[0], 3'b001);
    do_op(0, 16'd1, 16'd2, 4'b0110, 16'd1, 3'b010);
    do_op(0, 16'd1, 16'd2, 4'b1111, 16'd3, 3'b010);

    // reset during the grant cycle of a port-0 operation
    wait_idle();
    req0 = 1'b1; a0 = 16'd9; b0 = 16'd9; op0 = 4'b0000;
    @(negedge clk);
    chk("abort.gnt0_before", gnt0[0], 1'b1);
    rst_n = 1'b0; req0 = 1'b0;
    #1;
    chk("abort.gnt0", gnt0[0], 1'b0);
    chk("abort.busy", busy[0], 1'b0);
    chk("abort.res0", res0[0], 16'h0000);
    chk("abort.op",   aop[0],  4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort.no_done0", done0[0], 1'b0);
    end
    chk("abort.res0_after", res0[0], 16'h0000);

    // randomized traffic with occasional reset pulses
    repeat (400) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 63) != 0);
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      a0  = 16'($urandom); b0 = 16'($urandom); op0 = 4'($urandom);
      a1  = 16'($urandom); b1 = 16'($urandom); op1 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) b0 = a0;
      if ($urandom_range(0, 3) == 0) a1 = b1;
    end
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
